mips_boot_sequencer: RTL and testbench
======================================

Name: mips_boot_sequencer

Overview:
- Parametrised bring-up controller for the single-cycle MIPS core (`bne_cpu` family).
- Replaces fixed-delay reset pulses and file-based memory preloads with a streamed loader:
  - holds the CPU in reset;
  - writes a word stream into IMEM, then DMEM;
  - releases CPU reset after a programmable hold.
- Monitors the CPU data-memory write port for a stop write (status / watchdog).
- Sits between the bench/host link and the CPU top-level memories and reset.

Parameters:
- DATA_W, 32, word width of load stream, memories and CPU writedata/dataadr.
- IMEM_DEPTH, 64, instruction memory depth in words.
- DMEM_DEPTH, 64, data memory depth in words.
- RESET_HOLD, 2, cycles cpu_reset stays high after loading completes (minimum 1).
- STOP_ADDR, 32'h54, byte address whose CPU store ends the run.
- WDOG_CYCLES, 100, run-cycle budget before timeout (used only with watchdog).

Ports:
- clk, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- load_start, in, 1, 1-cycle pulse starting a load; sampled only in IDLE.
- imem_count, in, AW+1, IMEM words to load; sampled with load_start.
- dmem_count, in, AW+1, DMEM words to load; sampled with load_start.
- load_valid, in, 1, stream word valid.
- load_data, in, DATA_W, stream word.
- load_ready, out, 1, sequencer accepts a word this cycle.
- mem_addr, out, AW, word index for the current write, AW = $clog2(max(IMEM_DEPTH, DMEM_DEPTH)).
- mem_wdata, out, DATA_W, write data.
- imem_we, out, 1, IMEM write strobe.
- dmem_we, out, 1, DMEM write strobe.
- cpu_reset, out, 1, reset to CPU.
- cpu_memwrite, in, 1, CPU memwrite.
- cpu_dataadr, in, DATA_W, CPU dataadr.
- cpu_writedata, in, DATA_W, CPU writedata.
- running, out, 1, CPU out of reset and executing.
- done, out, 1, stop write seen; sticky until next load_start/reset.
- result, out, DATA_W, writedata captured at the stop write.
- run_cycles, out, 32, cycles spent in RUN; saturates at all-ones.
- timeout, out, 1, watchdog expired; sticky.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - cpu_reset=1.
  - All other outputs 0: load_ready, imem_we, dmem_we, running, done, timeout; result=0, run_cycles=0, mem_addr=0.
  - A reset mid-load or mid-run abandons the operation; memory contents are undefined.
- States: IDLE, LOAD_I, LOAD_D, HOLD, RUN, STOP.
- IDLE:
  - cpu_reset=1.
  - On load_start: latch counts, clamped to IMEM_DEPTH and DMEM_DEPTH respectively.
  - Clear done, timeout, result and run_cycles.
  - Go to LOAD_I, or to LOAD_D if imem count=0, or to HOLD if both counts=0.
- LOAD_I / LOAD_D:
  - load_ready=1.
  - A word transfers when load_valid && load_ready.
  - Write strobe is combinational in the same cycle as the transfer:
    - imem_we or dmem_we = load_valid;
    - mem_addr = word counter;
    - mem_wdata = load_data.
  - Counter increments per transfer.
  - After the last IMEM word, go to LOAD_D (counter reset to 0), or to HOLD if dmem count=0.
  - After the last DMEM word, go to HOLD.
  - No bubble between the phases: the cycle after the last IMEM write may accept DMEM word 0.
  - load_valid low stalls without penalty.
- HOLD:
  - cpu_reset=1 for exactly RESET_HOLD cycles, then go to RUN.
- RUN:
  - cpu_reset=0, running=1, run_cycles increments every cycle.
  - Stop condition: cpu_memwrite && cpu_dataadr==STOP_ADDR.
    - Capture result=cpu_writedata, set done=1, go to STOP.
  - Stores to other addresses are ignored.
- STOP:
  - cpu_reset=1, running=0.
  - done, result and run_cycles hold.
  - load_start is accepted here as in IDLE (re-load).
- load_start outside IDLE/STOP is ignored.
- Latency:
  - Starting from the load_start cycle, cpu_reset falls after 1 + imem_count + dmem_count + RESET_HOLD cycles when the stream is never stalled.

Optional Feature:
- Macro: BOOT_SEQ_WDOG_EN.
- When defined, a run-cycle watchdog is present:
  - If run_cycles reaches WDOG_CYCLES in RUN without a stop write, set timeout=1 and go to STOP with done=0.
  - If the stop write and expiry occur in the same cycle, the stop write wins: done=1, timeout=0.
- When undefined:
  - timeout is tied to 0.
  - RUN persists until the stop write or reset.

Decomposition:
- Package boot_seq_pkg holds:
  - state enum boot_state_t;
  - default DATA_W;
  - localparam helper for AW;
  - STOP_ADDR default constant.
- One natural sub-module: boot_seq_wdog, the saturating run counter plus watchdog compare.
  - Instantiated always; compare logic guarded by the macro.

Test Plan:
- Basic load and run:
  - Stimulus: load_start with imem_count=4, dmem_count=2, continuous valid.
  - Required: imem_we at addresses 0..3 and dmem_we at 0..1, back-to-back; cpu_reset falls exactly 1+6+2=9 cycles after load_start.
- Stalled stream:
  - Stimulus: load_valid low on alternate cycles.
  - Required: each word written once at a consecutive address; no write in cycles with valid=0.
- Stop write:
  - Stimulus: in RUN, drive memwrite with dataadr=0x50 then 0x54, writedata=7.
  - Required: 0x50 is ignored; on 0x54, done=1, result=7, cpu_reset=1 the next cycle, run_cycles frozen.
- Zero counts:
  - Stimulus: imem_count=0, dmem_count=0.
  - Required: IDLE→HOLD directly; no write strobes.
  - Stimulus: imem_count=100 with IMEM_DEPTH=64.
  - Required: exactly 64 IMEM writes.
- Asynchronous reset:
  - Stimulus: assert reset at word 3 of an IMEM load, between clock edges.
  - Required: outputs reach reset values immediately; a new load_start restarts at address 0.
- Watchdog (BOOT_SEQ_WDOG_EN):
  - Stimulus: WDOG_CYCLES=20, no stop write.
  - Required: timeout=1, done=0 after 20 RUN cycles.
  - Stimulus: stop write in cycle 20.
  - Required: done=1, timeout=0.

Source files
------------

// File: rtl/mips_boot_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// boot_seq_pkg
// Shared types and constants for the MIPS boot sequencer:
//   - boot_state_t : sequencer state encoding
//   - DATA_W_DEFAULT / STOP_ADDR_DEFAULT : default word width and stop address
//   - calcAw()     : word-index width covering the deeper of the two memories
// Optional feature macro used by the files that import this package:
//   BOOT_SEQ_WDOG_EN (run-cycle watchdog).
// ---------------------------------------------------------------------------
package boot_seq_pkg;

   localparam int          DATA_W_DEFAULT    = 32;
   localparam logic [31:0] STOP_ADDR_DEFAULT = 32'h54;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_I = 3'd1,
      ST_LOAD_D = 3'd2,
      ST_HOLD   = 3'd3,
      ST_RUN    = 3'd4,
      ST_STOP   = 3'd5
   } boot_state_t;

   // Width of a word index able to address the deeper memory. A depth of one
   // or two still gets a one-bit index so no port collapses to zero width.
   function automatic int calcAw(input int depthA, input int depthB);
      int deepest;
      deepest = (depthA > depthB) ? depthA : depthB;
      return (deepest <= 2) ? 1 : $clog2(deepest);
   endfunction

endpackage

// File: rtl/mips_boot_sequencer_if.sv
// ---------------------------------------------------------------------------
// mips_boot_sequencer_if
// Bundles every non-clock/reset signal of the boot sequencer.
//   Load stream  : load_start, imem_count, dmem_count, load_valid, load_data,
//                  load_ready
//   Memory write : mem_addr, mem_wdata, imem_we, dmem_we
//   CPU side     : cpu_reset, cpu_memwrite, cpu_dataadr, cpu_writedata
//   Status       : running, done, result, run_cycles, timeout
// Modports:
//   slave  - the sequencer itself
//   master - the host / bench / CPU-side environment driving it
// The timeout signal only carries information when BOOT_SEQ_WDOG_EN is set.
// ---------------------------------------------------------------------------
interface mips_boot_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int AW     = 6
);

   logic              load_start;
   logic [AW:0]       imem_count;
   logic [AW:0]       dmem_count;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;

   logic [AW-1:0]     mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              imem_we;
   logic              dmem_we;

   logic              cpu_reset;
   logic              cpu_memwrite;
   logic [DATA_W-1:0] cpu_dataadr;
   logic [DATA_W-1:0] cpu_writedata;

   logic              running;
   logic              done;
   logic [DATA_W-1:0] result;
   logic [31:0]       run_cycles;
   logic              timeout;

   modport slave (
      input  load_start, imem_count, dmem_count, load_valid, load_data,
      input  cpu_memwrite, cpu_dataadr, cpu_writedata,
      output load_ready, mem_addr, mem_wdata, imem_we, dmem_we,
      output cpu_reset, running, done, result, run_cycles, timeout
   );

   modport master (
      output load_start, imem_count, dmem_count, load_valid, load_data,
      output cpu_memwrite, cpu_dataadr, cpu_writedata,
      input  load_ready, mem_addr, mem_wdata, imem_we, dmem_we,
      input  cpu_reset, running, done, result, run_cycles, timeout
   );

endinterface

// File: rtl/mips_boot_sequencer_wdog.sv
// ---------------------------------------------------------------------------
// boot_seq_wdog
// Saturating count of cycles the CPU has spent running, plus the watchdog
// expiry compare.
// Ports:
//   clk, reset   : clock and asynchronous active-high reset
//   i_clear      : zero the counter (a new load was accepted)
//   i_run        : the sequencer is in RUN this cycle
//   o_runCycles  : cycles spent in RUN, sticks at all-ones
//   o_expire     : this RUN cycle is the WDOG_CYCLES-th one
// Macro BOOT_SEQ_WDOG_EN: when undefined the expiry output is tied low and
// only the counter remains.
// ---------------------------------------------------------------------------
module boot_seq_wdog #(
   parameter int WDOG_CYCLES = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_run,
   output logic [31:0] o_runCycles,
   output logic        o_expire
);

   logic [31:0] r_runCycles;

   // Run-cycle counter. A clear takes priority over counting so that a load
   // accepted from STOP always starts the next run from zero; once all-ones
   // the value is held rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_runCycles <= '0;
      end else if (i_clear) begin
         r_runCycles <= '0;
      end else if (i_run && (r_runCycles != '1)) begin
         r_runCycles <= r_runCycles + 32'd1;
      end
   end

   assign o_runCycles = r_runCycles;

`ifdef BOOT_SEQ_WDOG_EN
   // The counter shows the number of RUN cycles already completed, so the
   // budget is used up in the cycle where it still reads WDOG_CYCLES-1.
   // A budget of zero or one expires in the first RUN cycle.
   localparam logic [31:0] EXPIRE_AT = (WDOG_CYCLES < 1) ? 32'd0 : 32'(WDOG_CYCLES - 1);
   assign o_expire = i_run && (r_runCycles >= EXPIRE_AT);
`else
   assign o_expire = 1'b0;
`endif

endmodule

// File: rtl/mips_boot_sequencer.sv
// ---------------------------------------------------------------------------
// mips_boot_sequencer
// Bring-up controller for the single-cycle MIPS core. It keeps the CPU in
// reset, streams a word sequence into IMEM and then DMEM, holds reset for
// RESET_HOLD more cycles, lets the CPU run, and watches the data-memory write
// port for a store to STOP_ADDR that ends the run and captures its data.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : mips_boot_sequencer_if.slave carrying the load stream, the
//            memory write port, the CPU reset/store monitor and status
// Parameters: DATA_W, IMEM_DEPTH, DMEM_DEPTH, RESET_HOLD (>=1), STOP_ADDR,
//             WDOG_CYCLES.
// Macro BOOT_SEQ_WDOG_EN: enables the run-cycle watchdog; without it timeout
// is tied low and RUN lasts until the stop store or reset.
// ---------------------------------------------------------------------------
module mips_boot_sequencer
   import boot_seq_pkg::*;
#(
   parameter int          DATA_W      = DATA_W_DEFAULT,
   parameter int          IMEM_DEPTH  = 64,
   parameter int          DMEM_DEPTH  = 64,
   parameter int          RESET_HOLD  = 2,
   parameter logic [31:0] STOP_ADDR   = STOP_ADDR_DEFAULT,
   parameter int          WDOG_CYCLES = 100
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_boot_sequencer_if.slave  bus
);

   localparam int AW = calcAw(IMEM_DEPTH, DMEM_DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD);

   localparam logic [CW-1:0]     IMEM_MAX  = CW'(IMEM_DEPTH);
   localparam logic [CW-1:0]     DMEM_MAX  = CW'(DMEM_DEPTH);
   localparam logic [HW-1:0]     HOLD_LAST = (RESET_HOLD < 1) ? '0 : HW'(RESET_HOLD - 1);
   localparam logic [DATA_W-1:0] STOP_WORD = DATA_W'(STOP_ADDR);

   boot_state_t       r_state,    w_nextState;
   logic [CW-1:0]     r_imemCnt,  w_nextImemCnt;
   logic [CW-1:0]     r_dmemCnt,  w_nextDmemCnt;
   logic [CW-1:0]     r_wordCnt,  w_nextWordCnt;
   logic [HW-1:0]     r_holdCnt,  w_nextHoldCnt;
   logic              r_done,     w_nextDone;
   logic [DATA_W-1:0] r_result,   w_nextResult;
`ifdef BOOT_SEQ_WDOG_EN
   logic              r_timeout,  w_nextTimeout;
`endif

   logic [CW-1:0]     w_clampI;
   logic [CW-1:0]     w_clampD;
   logic              w_stopHit;
   logic              w_expire;
   logic              w_runClear;
   logic              w_inRun;
   logic [31:0]       w_runCycles;

   logic              w_loadReady;
   logic              w_imemWe;
   logic              w_dmemWe;
   logic [AW-1:0]     w_memAddr;
   logic [DATA_W-1:0] w_memWdata;
   logic              w_cpuReset;
   logic              w_running;

   // Requested word counts are limited to the physical memory depth so an
   // oversized request fills the memory exactly once and never wraps.
   assign w_clampI  = (bus.imem_count > IMEM_MAX) ? IMEM_MAX : bus.imem_count;
   assign w_clampD  = (bus.dmem_count > DMEM_MAX) ? DMEM_MAX : bus.dmem_count;

   assign w_stopHit = bus.cpu_memwrite && (bus.cpu_dataadr == STOP_WORD);

   boot_seq_wdog #(
      .WDOG_CYCLES (WDOG_CYCLES)
   ) u_wdog (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (w_runClear),
      .i_run       (w_inRun),
      .o_runCycles (w_runCycles),
      .o_expire    (w_expire)
   );

   // State and datapath registers. Everything is computed in the
   // combinational block below; this block only captures it, and reset puts
   // the sequencer back in IDLE with all status cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_imemCnt <= '0;
         r_dmemCnt <= '0;
         r_wordCnt <= '0;
         r_holdCnt <= '0;
         r_done    <= 1'b0;
         r_result  <= '0;
`ifdef BOOT_SEQ_WDOG_EN
         r_timeout <= 1'b0;
`endif
      end else begin
         r_state   <= w_nextState;
         r_imemCnt <= w_nextImemCnt;
         r_dmemCnt <= w_nextDmemCnt;
         r_wordCnt <= w_nextWordCnt;
         r_holdCnt <= w_nextHoldCnt;
         r_done    <= w_nextDone;
         r_result  <= w_nextResult;
`ifdef BOOT_SEQ_WDOG_EN
         r_timeout <= w_nextTimeout;
`endif
      end
   end

   // Next-state and output logic. During the load phases the memory write
   // strobe follows load_valid in the same cycle (ready is constantly high
   // there), so a stall costs nothing and the final IMEM transfer moves
   // straight on to DMEM word 0 in the next cycle. The word counter is
   // shared by both phases and restarts at zero between them. In RUN a stop
   // store is checked before watchdog expiry so it wins a same-cycle tie.
   always_comb begin
      w_nextState   = r_state;
      w_nextImemCnt = r_imemCnt;
      w_nextDmemCnt = r_dmemCnt;
      w_nextWordCnt = r_wordCnt;
      w_nextHoldCnt = r_holdCnt;
      w_nextDone    = r_done;
      w_nextResult  = r_result;
`ifdef BOOT_SEQ_WDOG_EN
      w_nextTimeout = r_timeout;
`endif
      w_runClear    = 1'b0;
      w_inRun       = 1'b0;
      w_loadReady   = 1'b0;
      w_imemWe      = 1'b0;
      w_dmemWe      = 1'b0;
      w_memAddr     = '0;
      w_memWdata    = '0;
      w_cpuReset    = 1'b1;
      w_running     = 1'b0;

      case (r_state)
         ST_IDLE, ST_STOP: begin
            if (bus.load_start) begin
               w_nextImemCnt = w_clampI;
               w_nextDmemCnt = w_clampD;
               w_nextWordCnt = '0;
               w_nextHoldCnt = '0;
               w_nextDone    = 1'b0;
               w_nextResult  = '0;
`ifdef BOOT_SEQ_WDOG_EN
               w_nextTimeout = 1'b0;
`endif
               w_runClear    = 1'b1;
               if (w_clampI != '0) begin
                  w_nextState = ST_LOAD_I;
               end else if (w_clampD != '0) begin
                  w_nextState = ST_LOAD_D;
               end else begin
                  w_nextState = ST_HOLD;
               end
            end
         end

         ST_LOAD_I: begin
            w_loadReady = 1'b1;
            w_imemWe    = bus.load_valid;
            w_memAddr   = r_wordCnt[AW-1:0];
            w_memWdata  = bus.load_data;
            if (bus.load_valid) begin
               if (r_wordCnt == (r_imemCnt - CW'(1))) begin
                  w_nextWordCnt = '0;
                  w_nextState   = (r_dmemCnt == '0) ? ST_HOLD : ST_LOAD_D;
               end else begin
                  w_nextWordCnt = r_wordCnt + CW'(1);
               end
            end
         end

         ST_LOAD_D: begin
            w_loadReady = 1'b1;
            w_dmemWe    = bus.load_valid;
            w_memAddr   = r_wordCnt[AW-1:0];
            w_memWdata  = bus.load_data;
            if (bus.load_valid) begin
               if (r_wordCnt == (r_dmemCnt - CW'(1))) begin
                  w_nextWordCnt = '0;
                  w_nextState   = ST_HOLD;
               end else begin
                  w_nextWordCnt = r_wordCnt + CW'(1);
               end
            end
         end

         ST_HOLD: begin
            if (r_holdCnt == HOLD_LAST) begin
               w_nextHoldCnt = '0;
               w_nextState   = ST_RUN;
            end else begin
               w_nextHoldCnt = r_holdCnt + HW'(1);
            end
         end

         ST_RUN: begin
            w_cpuReset = 1'b0;
            w_running  = 1'b1;
            w_inRun    = 1'b1;
            if (w_stopHit) begin
               w_nextResult = bus.cpu_writedata;
               w_nextDone   = 1'b1;
               w_nextState  = ST_STOP;
            end else if (w_expire) begin
`ifdef BOOT_SEQ_WDOG_EN
               w_nextTimeout = 1'b1;
`endif
               w_nextState   = ST_STOP;
            end
         end

         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   assign bus.load_ready = w_loadReady;
   assign bus.imem_we    = w_imemWe;
   assign bus.dmem_we    = w_dmemWe;
   assign bus.mem_addr   = w_memAddr;
   assign bus.mem_wdata  = w_memWdata;
   assign bus.cpu_reset  = w_cpuReset;
   assign bus.running    = w_running;
   assign bus.done       = r_done;
   assign bus.result     = r_result;
   assign bus.run_cycles = w_runCycles;
`ifdef BOOT_SEQ_WDOG_EN
   assign bus.timeout    = r_timeout;
`else
   assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_mips_boot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mips_boot_sequencer
// Randomised bench for mips_boot_sequencer. The reference model is the word
// stream itself: each accepted word k goes to IMEM index k while k is below
// the clamped IMEM count and to DMEM index k-ni afterwards; CPU release
// happens 1 + (driven load cycles) + RESET_HOLD cycles after load_start; a run
// ends on the first store to STOP_ADDR after that many RUN cycles.
// Compile with BOOT_SEQ_WDOG_EN to also exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_mips_boot_sequencer;
   import boot_seq_pkg::*;

   localparam int          DEPTH = 64;
   localparam int          AW    = calcAw(DEPTH, DEPTH);
   localparam int          HOLD  = 2;
   localparam int          WDOG  = 20;
   localparam logic [31:0] STOP  = 32'h54;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checkCount = 0;
   int   errCount   = 0;
   int   cycleNo    = 0;

   mips_boot_sequencer_if #(.DATA_W(32), .AW(AW)) bus ();

   mips_boot_sequencer #(
      .DATA_W      (32),
      .IMEM_DEPTH  (DEPTH),
      .DMEM_DEPTH  (DEPTH),
      .RESET_HOLD  (HOLD),
      .STOP_ADDR   (STOP),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock and cycle index used for latency measurement.
   always #5 clk = ~clk;
   always @(posedge clk) cycleNo <= cycleNo + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Every output must be at its reset value while reset is asserted.
   task automatic checkResetState(input string phase);
      checkOutput({phase, "_cpu_reset"},  32'(bus.cpu_reset), 32'd1);
      checkOutput({phase, "_load_ready"}, 32'(bus.load_ready), 32'd0);
      checkOutput({phase, "_we"},         32'({bus.imem_we, bus.dmem_we}), 32'd0);
      checkOutput({phase, "_running"},    32'(bus.running), 32'd0);
      checkOutput({phase, "_done"},       32'(bus.done), 32'd0);
      checkOutput({phase, "_timeout"},    32'(bus.timeout), 32'd0);
      checkOutput({phase, "_result"},     bus.result, 32'd0);
      checkOutput({phase, "_run_cycles"}, bus.run_cycles, 32'd0);
      checkOutput({phase, "_mem_addr"},   32'(bus.mem_addr), 32'd0);
   endtask

   // Reset asserted between clock edges, checked before the next edge.
   task automatic doReset(input string phase);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkResetState(phase);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Issue a load of ic/dc words with random stalls and follow it to the
   // first RUN cycle. Returns at the negedge of that first RUN cycle.
   task automatic applyStimulus(input int ic, input int dc, input int stallPct);
      int          ni, nd, total, sent, stalls, guard;
      int          startCyc, relCyc;
      logic        v;
      logic [31:0] d;
      logic [1:0]  expWe;
      int          expAddr;
      bit          released;

      ni     = (ic > DEPTH) ? DEPTH : ic;
      nd     = (dc > DEPTH) ? DEPTH : dc;
      total  = ni + nd;
      sent   = 0;
      stalls = 0;
      guard  = 0;

      @(posedge clk);
      #1;
      bus.load_start = 1'b1;
      bus.imem_count = (AW+1)'(ic);
      bus.dmem_count = (AW+1)'(dc);
      bus.load_valid = 1'b0;
      startCyc = cycleNo;

      @(posedge clk);
      #1;
      bus.load_start = 1'b0;
      checkOutput("clr_done",       32'(bus.done), 32'd0);
      checkOutput("clr_result",     bus.result, 32'd0);
      checkOutput("clr_run_cycles", bus.run_cycles, 32'd0);
      checkOutput("clr_timeout",    32'(bus.timeout), 32'd0);

      while ((sent < total) && (guard < 4000)) begin
         v = ($urandom_range(0, 99) >= stallPct);
         d = $urandom;
         bus.load_valid = v;
         bus.load_data  = d;
         @(negedge clk);
         checkOutput("load_ready", 32'(bus.load_ready), 32'd1);
         if (v) begin
            if (sent < ni) begin
               expWe   = 2'b10;
               expAddr = sent;
            end else begin
               expWe   = 2'b01;
               expAddr = sent - ni;
            end
            checkOutput("write_we",    32'({bus.imem_we, bus.dmem_we}), 32'(expWe));
            checkOutput("write_addr",  32'(bus.mem_addr), 32'(expAddr));
            checkOutput("write_wdata", bus.mem_wdata, d);
            sent++;
         end else begin
            checkOutput("stall_we", 32'({bus.imem_we, bus.dmem_we}), 32'd0);
            stalls++;
         end
         guard++;
         @(posedge clk);
         #1;
      end
      bus.load_valid = 1'b0;
      if (sent < total) checkOutput("load_budget", 32'(sent), 32'(total));

      released = 1'b0;
      for (int w = 0; w < 50; w++) begin
         @(negedge clk);
         if (bus.cpu_reset == 1'b0) begin
            released = 1'b1;
            break;
         end
         checkOutput("hold_we",    32'({bus.imem_we, bus.dmem_we}), 32'd0);
         checkOutput("hold_ready", 32'(bus.load_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      relCyc = cycleNo;
      checkOutput("release_seen", 32'(released), 32'd1);
      checkOutput("release_latency", 32'(relCyc - startCyc), 32'(1 + total + stalls + HOLD));
      checkOutput("release_running", 32'(bus.running), 32'd1);
   endtask

   // Let the CPU run. The stop store (when doStop) lands in RUN cycle stopAt
   // (1-based, >= 3), preceded by a store to 0x50 and random other stores,
   // plus an ignored load_start in cycle 2. Without doStop the run is left
   // to the watchdog and stopAt is the expected expiry cycle.
   task automatic runPhase(input int stopAt, input bit doStop, input logic [31:0] wd);
      logic [31:0] a;
      logic [31:0] expRes;
      logic        expTimeout;

      checkOutput("run_start_cycles", bus.run_cycles, 32'd0);
      checkOutput("run_start_done",   32'(bus.done), 32'd0);
      for (int c = 2; c <= stopAt; c++) begin
         @(posedge clk);
         #1;
         bus.cpu_memwrite = 1'b0;
         bus.load_start   = 1'b0;
         if ((c == stopAt) && doStop) begin
            bus.cpu_memwrite  = 1'b1;
            bus.cpu_dataadr   = STOP;
            bus.cpu_writedata = wd;
         end else if ((c == stopAt - 1) && doStop) begin
            bus.cpu_memwrite  = 1'b1;
            bus.cpu_dataadr   = 32'h50;
            bus.cpu_writedata = $urandom;
         end else if (c == 2) begin
            bus.load_start = 1'b1;
            bus.imem_count = (AW+1)'(3);
            bus.dmem_count = (AW+1)'(3);
         end else if ($urandom_range(0, 3) == 0) begin
            a = 32'($urandom_range(0, 255)) * 32'd4;
            if (a == STOP) a = a + 32'd4;
            bus.cpu_memwrite  = 1'b1;
            bus.cpu_dataadr   = a;
            bus.cpu_writedata = $urandom;
         end
         @(negedge clk);
         checkOutput("run_running",   32'(bus.running), 32'd1);
         checkOutput("run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.cpu_memwrite = 1'b0;
      bus.load_start   = 1'b0;

      expRes     = doStop ? wd : 32'd0;
      expTimeout = !doStop;
`ifndef BOOT_SEQ_WDOG_EN
      expTimeout = 1'b0;
`endif
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         checkOutput("stop_done",       32'(bus.done), 32'(doStop));
         checkOutput("stop_timeout",    32'(bus.timeout), 32'(expTimeout));
         checkOutput("stop_result",     bus.result, expRes);
         checkOutput("stop_cpu_reset",  32'(bus.cpu_reset), 32'd1);
         checkOutput("stop_running",    32'(bus.running), 32'd0);
         checkOutput("stop_run_cycles", bus.run_cycles, 32'(stopAt));
      end
   endtask

   initial begin
      bus.load_start    = 1'b0;
      bus.imem_count    = '0;
      bus.dmem_count    = '0;
      bus.load_valid    = 1'b0;
      bus.load_data     = '0;
      bus.cpu_memwrite  = 1'b0;
      bus.cpu_dataadr   = '0;
      bus.cpu_writedata = '0;

      #3;
      checkResetState("por");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      $display("[TB] basic load 4+2 and stop write");
      applyStimulus(4, 2, 0);
      runPhase(5, 1'b1, 32'd7);

      $display("[TB] reload from STOP with stalled stream");
      applyStimulus(6, 5, 50);
      runPhase(8, 1'b1, $urandom);

      $display("[TB] zero counts");
      applyStimulus(0, 0, 0);
      runPhase(3, 1'b1, $urandom);

      $display("[TB] DMEM only");
      applyStimulus(0, 4, 30);
      runPhase(4, 1'b1, $urandom);

      $display("[TB] oversized IMEM count");
      applyStimulus(100, 3, 20);
      runPhase(6, 1'b1, $urandom);

      $display("[TB] random loads");
      for (int r = 0; r < 4; r++) begin
         applyStimulus($urandom_range(0, 70), $urandom_range(0, 70), $urandom_range(0, 60));
         runPhase($urandom_range(3, 15), 1'b1, $urandom);
      end

      $display("[TB] reset while stopped");
      doReset("rst_stop");

      $display("[TB] reset in the middle of an IMEM load");
      @(posedge clk);
      #1;
      bus.load_start = 1'b1;
      bus.imem_count = (AW+1)'(10);
      bus.dmem_count = (AW+1)'(0);
      @(posedge clk);
      #1;
      bus.load_start = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = $urandom;
      repeat (3) begin
         @(posedge clk);
         #1;
         bus.load_data = $urandom;
      end
      checkOutput("midload_addr", 32'(bus.mem_addr), 32'd3);
      checkOutput("midload_we",   32'(bus.imem_we), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkResetState("rst_load");
      bus.load_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(5, 3, 0);
      runPhase(4, 1'b1, $urandom);

`ifdef BOOT_SEQ_WDOG_EN
      $display("[TB] watchdog expiry");
      applyStimulus(2, 2, 0);
      runPhase(WDOG, 1'b0, 32'd0);
      $display("[TB] stop write on the expiry cycle");
      applyStimulus(2, 2, 0);
      runPhase(WDOG, 1'b1, $urandom);
`else
      $display("[TB] long run without watchdog");
      applyStimulus(2, 2, 0);
      runPhase(40, 1'b1, $urandom);
`endif

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
